// File: rtl/state_seq_pkg.sv
// state_seq_pkg: shared types and constants for the millisecond phase sequencer.
//   state_e        FSM state encoding
//   sel_rep/ctrl   register-select codes for the repeat count and control word;
//                  they sit directly above the NPHASE duration registers
//   CTRL_UNIT_BIT  ctrl bit choosing PRESC-cycle ticks (1) or single clk_sys ticks (0)
package state_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam int CTRL_UNIT_BIT = 0;

  function automatic int sel_rep(input int nphase);
    return nphase;
  endfunction

  function automatic int sel_ctrl(input int nphase);
    return nphase + 1;
  endfunction

endpackage

// File: rtl/state_seq_tick.sv
// state_seq_tick: tick-enable generator for the phase counter.
//   clk_i   system clock
//   rst_i   synchronous active-high reset
//   clr_i   synchronous prescaler clear (held while a phase is being set up)
//   en_i    count enable (phase running)
//   unit_i  1 = one tick every PRESC cycles, 0 = tick every cycle
//   tick_o  tick enable, only ever high while en_i
module state_seq_tick #(
  parameter int PRESC = 10000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  input  logic unit_i,
  output logic tick_o
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic [PW-1:0] pcnt_q;
  logic          wrap;

  assign wrap = (pcnt_q == PW'(PRESC - 1));

  // Cleared before each phase so the first tick lands exactly PRESC cycles in.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i)
      pcnt_q <= '0;
    else if (en_i && unit_i)
      pcnt_q <= wrap ? '0 : pcnt_q + PW'(1);
  end

  assign tick_o = en_i && (!unit_i || wrap);

endmodule

// File: rtl/state_seq_ms.sv
// state_seq_ms: programmable phase sequencer. Runs NPHASE timed phases in order,
// skipping zero-length ones, for rep passes (rep=0 runs until seq_stop).
//   clk_sys        system clock
//   state_seq_rst  synchronous active-high reset
//   seq_start      start request, honoured only in IDLE
//   seq_stop       abort from any state, no seq_done
//   load/loadchoice/datain  register write: dur[0..NPHASE-1], rep, ctrl
//   phase_out      level, bit i high while phase i runs
//   phase_start    one-cycle strobe on the first cycle of phase i
//   busy           high in any non-IDLE state
//   seq_done       one-cycle pulse on normal completion
//   cycle_cnt      completed passes in the current run (saturating)
module state_seq_ms
  import state_seq_pkg::*;
#(
  parameter int NPHASE = 6,
  parameter int CNT_W  = 16,
  parameter int PRESC  = 10000,
  parameter int SEL_W  = 4
) (
  input  logic              clk_sys,
  input  logic              state_seq_rst,
  input  logic              seq_start,
  input  logic              seq_stop,
  input  logic              load,
  input  logic [SEL_W-1:0]  loadchoice,
  input  logic [15:0]       datain,
  output logic [NPHASE-1:0] phase_out,
  output logic [NPHASE-1:0] phase_start,
  output logic              busy,
  output logic              seq_done,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam int                IW       = $clog2(NPHASE);
  localparam int                SEL_REP  = sel_rep(NPHASE);
  localparam int                SEL_CTRL = sel_ctrl(NPHASE);
  localparam logic [NPHASE-1:0] ONE_1H   = NPHASE'(1);

  // Programming registers
  logic [CNT_W-1:0] dur_q [NPHASE];
  logic [CNT_W-1:0] rep_q;
  logic             unit_q;

  // Sequencer state
  state_e           state_q;
  logic [IW-1:0]    idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             unit_lat_q;
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [NPHASE-1:0] phase_out_q, phase_start_q;
  logic             busy_q, seq_done_q;

  logic [CNT_W-1:0]  dur_cur, cyc_inc, adv_cyc;
  logic [IW-1:0]     adv_idx;
  logic [NPHASE-1:0] sel_1h;
  logic              pass_end, more, adv_done, tick, tick_clr, tick_en;

  always_ff @(posedge clk_sys) begin
    if (state_seq_rst) begin
      for (int i = 0; i < NPHASE; i++) dur_q[i] <= '0;
      rep_q  <= CNT_W'(1);
      unit_q <= 1'b0;
    end else if (load) begin
      for (int i = 0; i < NPHASE; i++)
        if (loadchoice == SEL_W'(i)) dur_q[i] <= datain[CNT_W-1:0];
      if (loadchoice == SEL_W'(SEL_REP))  rep_q  <= datain[CNT_W-1:0];
      if (loadchoice == SEL_W'(SEL_CTRL)) unit_q <= datain[CTRL_UNIT_BIT];
    end
  end

  always_comb begin
    dur_cur = '0;
    for (int i = 0; i < NPHASE; i++)
      if (idx_q == IW'(i)) dur_cur = dur_q[i];
  end

  // Advance bookkeeping shared by a skipped phase (EVAL) and an expiring one (RUN).
  // rep is compared live, widened so a saturated cycle_cnt cannot wrap the test.
  assign pass_end = (idx_q == IW'(NPHASE - 1));
  assign cyc_inc  = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
  assign more     = (rep_q == '0) ||
                    (({1'b0, cycle_cnt_q} + (CNT_W+1)'(1)) < {1'b0, rep_q});
  assign adv_idx  = pass_end ? '0 : idx_q + IW'(1);
  assign adv_cyc  = pass_end ? cyc_inc : cycle_cnt_q;
  assign adv_done = pass_end && !more;
  assign sel_1h   = ONE_1H << idx_q;

  assign tick_clr = (state_q == ST_EVAL);
  assign tick_en  = (state_q == ST_RUN);

  state_seq_tick #(.PRESC(PRESC)) u_tick (
    .clk_i  (clk_sys),
    .rst_i  (state_seq_rst),
    .clr_i  (tick_clr),
    .en_i   (tick_en),
    .unit_i (unit_lat_q),
    .tick_o (tick)
  );

  always_ff @(posedge clk_sys) begin
    if (state_seq_rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      unit_lat_q    <= 1'b0;
      cycle_cnt_q   <= '0;
      phase_out_q   <= '0;
      phase_start_q <= '0;
      busy_q        <= 1'b0;
      seq_done_q    <= 1'b0;
    end else if (seq_stop) begin
      // Abort: cycle_cnt deliberately held for post-mortem readout.
      state_q       <= ST_IDLE;
      phase_out_q   <= '0;
      phase_start_q <= '0;
      busy_q        <= 1'b0;
      seq_done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (seq_start) begin
            state_q     <= ST_EVAL;
            idx_q       <= '0;
            cycle_cnt_q <= '0;
            busy_q      <= 1'b1;
          end
        end
        ST_EVAL: begin
          if (dur_cur == '0) begin
            idx_q       <= adv_idx;
            cycle_cnt_q <= adv_cyc;
            seq_done_q  <= adv_done;
            state_q     <= adv_done ? ST_DONE : ST_EVAL;
          end else begin
            // Duration and unit are captured here; later writes wait for next entry.
            cnt_q         <= dur_cur;
            unit_lat_q    <= unit_q;
            phase_out_q   <= sel_1h;
            phase_start_q <= sel_1h;
            state_q       <= ST_RUN;
          end
        end
        ST_RUN: begin
          phase_start_q <= '0;
          if (tick) begin
            if (cnt_q == CNT_W'(1)) begin
              phase_out_q <= '0;
              idx_q       <= adv_idx;
              cycle_cnt_q <= adv_cyc;
              seq_done_q  <= adv_done;
              state_q     <= adv_done ? ST_DONE : ST_EVAL;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          seq_done_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign phase_out   = phase_out_q;
  assign phase_start = phase_start_q;
  assign busy        = busy_q;
  assign seq_done    = seq_done_q;
  assign cycle_cnt   = cycle_cnt_q;

endmodule

// File: tb/tb_state_seq_ms.sv
// tb_state_seq_ms: directed bench for state_seq_ms with hand-derived timelines.
// DUT built with PRESC=4 so the prescaled-unit case stays short.
module tb_state_seq_ms;

  localparam int NP = 6;
  localparam int CW = 16;
  localparam int SW = 4;

  logic          clk_sys = 1'b0;
  logic          rst, seq_start, seq_stop, load;
  logic [SW-1:0] loadchoice;
  logic [15:0]   datain;
  logic [NP-1:0] phase_out, phase_start;
  logic          busy, seq_done;
  logic [CW-1:0] cycle_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  logic [NP-1:0] po [64];
  logic [NP-1:0] ps [64];
  logic          dn [64];
  logic          bz [64];

  always #5 clk_sys = ~clk_sys;

  state_seq_ms #(.NPHASE(NP), .CNT_W(CW), .PRESC(4), .SEL_W(SW)) dut (
    .clk_sys       (clk_sys),
    .state_seq_rst (rst),
    .seq_start     (seq_start),
    .seq_stop      (seq_stop),
    .load          (load),
    .loadchoice    (loadchoice),
    .datain        (datain),
    .phase_out     (phase_out),
    .phase_start   (phase_start),
    .busy          (busy),
    .seq_done      (seq_done),
    .cycle_cnt     (cycle_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr(input int sel, input int val);
    loadchoice = SW'(sel);
    datain     = 16'(val);
    load       = 1'b1;
    step();
    load       = 1'b0;
  endtask

  task automatic go();
    seq_start = 1'b1;
    step();
    seq_start = 1'b0;
  endtask

  task automatic cap(input int n);
    for (int i = 0; i < n; i++) begin
      po[i] = phase_out; ps[i] = phase_start; dn[i] = seq_done; bz[i] = busy;
      step();
    end
  endtask

  function automatic int n_ps(input int n, input int b);
    int c = 0;
    for (int i = 0; i < n; i++) if (ps[i][b]) c++;
    return c;
  endfunction

  function automatic int n_dn(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (dn[i]) c++;
    return c;
  endfunction

  function automatic int n_any(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (po[i] != '0 || bz[i]) c++;
    return c;
  endfunction

  // Length of the k-th (1-based) high run of phase_out[b].
  function automatic int run_len(input int n, input int b, input int k);
    int r = 0;
    int len = 0;
    bit prev = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (po[i][b] && !prev) r++;
      if (po[i][b] && r == k) len++;
      prev = po[i][b];
    end
    return len;
  endfunction

  initial begin
    logic [NP-1:0] exp1 [14];
    int c;
    exp1 = '{6'h00, 6'h01, 6'h01, 6'h01, 6'h00, 6'h00, 6'h04,
             6'h04, 6'h00, 6'h00, 6'h00, 6'h20, 6'h00, 6'h00};
    rst = 1'b1; seq_start = 1'b0; seq_stop = 1'b0; load = 1'b0;
    loadchoice = '0; datain = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_po",   phase_out, 0);
    chk("rst_ps",   phase_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", seq_done, 0);
    chk("rst_cyc",  cycle_cnt, 0);

    // 1: unit 0, dur={3,0,2,0,0,1}, rep 1
    wr(0, 3); wr(2, 2); wr(5, 1);
    go();
    cap(14);
    for (int i = 0; i < 14; i++) chk($sformatf("t1_po%0d", i), po[i], exp1[i]);
    chk("t1_ps0",    ps[1], 6'h01);
    chk("t1_ps2",    ps[6], 6'h04);
    chk("t1_done12", dn[12], 1);
    chk("t1_ndone",  n_dn(14), 1);
    chk("t1_busy0",  bz[0], 1);
    chk("t1_busy13", bz[13], 0);
    chk("t1_cyc",    cycle_cnt, 1);

    // 2: unit 1 (PRESC 4), dur[0]=2 others 0 -> 8-cycle phase
    wr(2, 0); wr(5, 0); wr(0, 2); wr(NP + 1, 1);
    go();
    cap(20);
    chk("t2_len",   run_len(20, 0, 1), 8);
    chk("t2_first", po[1], 6'h01);
    chk("t2_after", po[9], 6'h00);
    chk("t2_done",  dn[14], 1);
    chk("t2_ndone", n_dn(20), 1);
    wr(NP + 1, 0);

    // 3: rep 3, all dur 1 -> 36 cycles then DONE
    for (int i = 0; i < NP; i++) wr(i, 1);
    wr(NP, 3);
    go();
    cap(40);
    chk("t3_ps0",   n_ps(40, 0), 3);
    chk("t3_ps5",   n_ps(40, 5), 3);
    chk("t3_done",  dn[36], 1);
    chk("t3_ndone", n_dn(40), 1);
    chk("t3_cyc",   cycle_cnt, 3);

    // 4: rep 0, stop in the middle of phase 2 on the second pass
    wr(NP, 0); wr(2, 4);
    go();
    c = 0;
    for (int i = 0; i < 100; i++) begin
      if (phase_start[2]) begin
        c++;
        if (c == 2) break;
      end
      step();
    end
    chk("t4_wait", c, 2);
    step();
    chk("t4_mid", phase_out, 6'h04);
    seq_stop = 1'b1;
    step();
    seq_stop = 1'b0;
    chk("t4_po",   phase_out, 0);
    chk("t4_busy", busy, 0);
    chk("t4_cyc",  cycle_cnt, 1);
    cap(10);
    chk("t4_ndone", n_dn(10), 0);
    chk("t4_idle",  n_any(10), 0);
    seq_start = 1'b1; seq_stop = 1'b1;
    step();
    seq_start = 1'b0; seq_stop = 1'b0;
    chk("t4_ss_busy", busy, 0);

    // 5: dur={1,2,1,1,1,1}, rep 2; rewrite dur[1] mid-phase and at phase entry
    wr(NP, 2); wr(1, 2); wr(2, 1);
    go();
    for (int i = 0; i < 40; i++) begin
      po[i] = phase_out; ps[i] = phase_start; dn[i] = seq_done; bz[i] = busy;
      if (i == 3)       begin loadchoice = 4'd1; datain = 16'd5; load = 1'b1; end
      else if (i == 15) begin loadchoice = 4'd1; datain = 16'd7; load = 1'b1; end
      else load = 1'b0;
      step();
    end
    load = 1'b0;
    chk("t5_in_p1", po[3], 6'h02);
    chk("t5_eval",  po[15], 6'h00);
    chk("t5_len1",  run_len(40, 1, 1), 2);
    chk("t5_len2",  run_len(40, 1, 2), 5);
    chk("t5_ndone", n_dn(40), 1);
    chk("t5_cyc",   cycle_cnt, 2);

    // 6: reset mid-run restores defaults -> all-skip single pass
    wr(0, 3);
    go();
    step();
    chk("t6_run", phase_out, 6'h01);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_po",   phase_out, 0);
    chk("t6_busy", busy, 0);
    chk("t6_cyc0", cycle_cnt, 0);
    go();
    cap(10);
    chk("t6_done",  dn[6], 1);
    chk("t6_ndone", n_dn(10), 1);
    chk("t6_cyc",   cycle_cnt, 1);
    c = 0;
    for (int i = 0; i < 10; i++) if (po[i] != '0) c++;
    chk("t6_nopo", c, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/state_seq_ms.md
# state_seq_ms

Parametrised millisecond phase sequencer for the NMR pulse/echo front end; successor to the fixed six-output 1 ms state block. It runs a programmable sequence of up to NPHASE timed phases, optionally repeated, with durations loaded over the existing load/loadchoice/datain register bus. Each phase drives one level output and one entry strobe, used for reset, dump, pulse, bridge cycle, receive switch and soft dump.

## Interface
- NPHASE, 6: number of phases/outputs (2..14)
- CNT_W, 16: duration/repeat counter width (≤16, datain width)
- PRESC, 10000: clk_sys cycles per tick (10 MHz → 1 ms)
- SEL_W, 4: loadchoice width; 2^SEL_W ≥ NPHASE+2

- clk_sys  in  1  system clock, all logic on rising edge
- state_seq_rst  in  1  synchronous, active-high reset
- seq_start  in  1  start request, level-sampled, acted on only in IDLE
- seq_stop  in  1  abort request, any state
- load  in  1  register write strobe, one cycle
- loadchoice  in  SEL_W  register select
- datain  in  16  write data; low CNT_W bits used
- phase_out  out  NPHASE  level, bit i high during phase i
- phase_start  out  NPHASE  one-cycle strobe on first cycle of phase i
- busy  out  1  high in any non-IDLE state
- seq_done  out  1  one-cycle pulse on normal completion
- cycle_cnt  out  CNT_W  completed passes in current run

## Operation
- Registers: loadchoice 0..NPHASE-1 = dur[i] (ticks); NPHASE = rep (passes, 0 = run until stop); NPHASE+1 = ctrl, bit0 unit (1 = PRESC-cycle tick, 0 = single clk_sys cycle). Other selects ignored.
- Writes are accepted while busy; dur[i] and unit are latched into the working counter at phase i entry, so a write takes effect from the next entry of that phase. rep is compared live.
- FSM: IDLE → EVAL → RUN → EVAL … → DONE → IDLE.
- IDLE: outputs low; seq_start && !seq_stop → EVAL, idx=0, cycle_cnt=0.
- EVAL (1 cycle, all phase_out low): dur[idx]==0 → skip (idx advance, stay EVAL); else load counter with dur[idx], clear prescaler → RUN.
- RUN: phase_out[idx]=1; phase_start[idx]=1 first cycle only. Counter decrements per tick; at expiry, idx advances → EVAL.
- Advance past NPHASE-1: cycle_cnt+1; if rep==0 or cycle_cnt+1 < rep → idx=0, EVAL; else DONE.
- DONE (1 cycle): seq_done=1 → IDLE.
- seq_stop in any state: → IDLE next edge, outputs low, no seq_done; cycle_cnt held.
- All dur zero: each pass costs NPHASE EVAL cycles; rep==0 with all zero loops silently until stop.
- cycle_cnt saturates at 2^CNT_W-1.

## Timing
- Reset values: dur[*]=0, rep=1, ctrl=0, state IDLE, all outputs 0, cycle_cnt 0.
- seq_start sampled high at edge k → EVAL after k; phase_out[0]/phase_start[0] high after edge k+1.
- Phase length exactly dur×1 cycles (unit 0) or dur×PRESC cycles (unit 1); one-cycle all-low gap per EVAL, including skipped phases.
- seq_done asserted the cycle after the last phase_out deasserts plus one EVAL-free cycle (RUN → DONE direct on final expiry).
- seq_start while busy ignored; seq_start and seq_stop together in IDLE: stay IDLE.
- load in same cycle as phase entry for that phase: new value is NOT used (old latched).
- state_seq_rst mid-run: IDLE and register defaults next edge.

## Structure
- state_seq_pkg: FSM state enum, loadchoice constants (SEL_REP, SEL_CTRL as functions of NPHASE), ctrl bit index.
- Sub-module state_seq_tick: PRESC prescaler with sync clear and unit bypass, emits tick enable.

## Test plan
- unit=0, dur={3,0,2,0,0,1}, rep=1, start → phase0 high 3 cycles, gap, skip, phase2 2 cycles, …, phase5 1 cycle, seq_done once, cycle_cnt=1.
- unit=1, PRESC=4 (override), dur[0]=2 others 0 → phase_out[0] high exactly 8 cycles.
- rep=3, dur all 1 → three passes, phase_start[0] pulses 3×, cycle_cnt=3, single seq_done.
- rep=0, run; seq_stop mid phase2 → outputs low next edge, busy 0, no seq_done.
- write dur[1]=5 while in phase1 (was 2) → current phase1 lasts 2, next pass 5.
- state_seq_rst during RUN → all outputs 0, dur readback behaviour = restart produces immediate all-skip pass and seq_done.
